// File: rtl/cpu_pkg.sv
// Purpose: shared opcodes, state encoding and instruction field positions for the control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // Opcode field values. Codes 0x0-0x9 double as the ALU select encoding.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_NAND  = 4'h3;
    localparam logic [3:0] OP_SHL   = 4'h4;
    localparam logic [3:0] OP_SHR   = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_IN    = 4'h7;
    localparam logic [3:0] OP_MOV   = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_BZ    = 4'hA;
    localparam logic [3:0] OP_BN    = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_NOPD  = 4'hD;
    localparam logic [3:0] OP_NOPE  = 4'hE;
    localparam logic [3:0] OP_HLT   = 4'hF;

    // Flag bit positions within {Z,N}.
    localparam int Z_IDX = 1;
    localparam int N_IDX = 0;

    // Instruction byte fields: [7:4] opcode, [3:2] rd, [1:0] rs.
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int RD_HI  = 3;
    localparam int RD_LO  = 2;
    localparam int RS_HI  = 1;
    localparam int RS_LO  = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WAIT_IN,
        WAIT_OUT,
        FETCH_IMM,
        BRANCH,
        HALT
    } state_t;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BZ) || (op == OP_BN) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Purpose: decide whether a branch opcode is taken given the latched {Z,N} flags.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode (4, in), flags (2, in), taken (1, out; 0 for non-branch opcodes).
import cpu_pkg::*;

module branch_eval (
    input  logic [3:0] opcode,
    input  logic [1:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BZ:   taken = flags[Z_IDX];
            OP_BN:   taken = flags[N_IDX];
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Purpose: multi-cycle fetch/decode/execute sequencer driving ALU select, regfile/memory strobes, flags, branches and IN/OUT port.
// Latency: 3 cycles per ALU/MOV/STORE/NOP, 4 per branch, 3 + wait cycles per IN/OUT; HALT is terminal until rst.
// Backpressure: WAIT_IN holds with in_ready=1 until in_valid; WAIT_OUT holds with out_valid=1 until out_ready.
// Ports: clk/rst (sync active-high); pc/instr to the synchronous ROM; alu_sel/alu_flag to the ALU;
//        rf_ra/rf_rb/rf_wa/rf_we/rf_wsel to the register file; mem_we to data memory;
//        in_valid/in_ready and out_valid/out_ready port handshakes; flags (latched {Z,N}); halted.
import cpu_pkg::*;

module control_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    input  logic [7:0]        instr,
    output logic [3:0]        alu_sel,
    input  logic [1:0]        alu_flag,
    output logic [1:0]        rf_ra,
    output logic [1:0]        rf_rb,
    output logic [1:0]        rf_wa,
    output logic              rf_we,
    output logic              rf_wsel,
    output logic              mem_we,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        flags,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  ir;
    logic [3:0]  op;
    logic [3:0]  dec_op;
    logic        taken;

    // Decoded fields come from the latched ir, so they hold steady through EXEC and the wait states.
    assign op     = ir[OPC_HI:OPC_LO];
    assign dec_op = instr[OPC_HI:OPC_LO];
    assign rf_ra  = ir[RD_HI:RD_LO];
    assign rf_rb  = ir[RS_HI:RS_LO];
    assign rf_wa  = ir[RD_HI:RD_LO];

    branch_eval u_branch_eval (
        .opcode (op),
        .flags  (flags),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                DECODE: begin
                    ir <= instr;
                    pc <= pc + PC_ONE;
                end
                EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_NAND: flags <= alu_flag;
                        // Shifts report the shifted-out bit on Z; N keeps its previous meaning.
                        OP_SHL, OP_SHR:          flags[Z_IDX] <= alu_flag[Z_IDX];
                        default: ;
                    endcase
                end
                // instr here is the target byte read during FETCH_IMM.
                BRANCH: pc <= taken ? ADDR_W'(instr) : pc + PC_ONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        alu_sel   = OP_NOP;
        rf_we     = 1'b0;
        rf_wsel   = 1'b0;
        mem_we    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;

        case (state)
            FETCH: state_nxt = DECODE;

            DECODE: begin
                if (dec_op == OP_IN)           state_nxt = WAIT_IN;
                else if (dec_op == OP_OUT)     state_nxt = WAIT_OUT;
                else if (is_branch(dec_op))    state_nxt = FETCH_IMM;
                else if (dec_op == OP_HLT)     state_nxt = HALT;
                else                           state_nxt = EXEC;
            end

            EXEC: begin
                state_nxt = FETCH;
                case (op)
                    OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR, OP_MOV: begin
                        alu_sel = op;
                        rf_we   = 1'b1;
                    end
                    OP_STORE: begin
                        alu_sel = op;
                        mem_we  = 1'b1;
                    end
                    // NOP and the spare codes 0xD/0xE present a plain NOP to the ALU.
                    default: ;
                endcase
            end

            WAIT_IN: begin
                alu_sel  = OP_IN;
                in_ready = 1'b1;
                if (in_valid) begin
                    rf_we     = 1'b1;
                    rf_wsel   = 1'b1;
                    state_nxt = FETCH;
                end
            end

            WAIT_OUT: begin
                alu_sel   = OP_OUT;
                out_valid = 1'b1;
                if (out_ready) state_nxt = FETCH;
            end

            FETCH_IMM: state_nxt = BRANCH;
            BRANCH:    state_nxt = FETCH;
            HALT:      halted    = 1'b1;
            default:   state_nxt = FETCH;
        endcase

        // Reset aborts whatever is in flight: no write or transfer may land on the reset edge.
        if (rst) begin
            alu_sel   = OP_NOP;
            rf_we     = 1'b0;
            rf_wsel   = 1'b0;
            mem_we    = 1'b0;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            halted    = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
module tb_control_unit;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        instr;
    logic [3:0]        alu_sel;
    logic [1:0]        alu_flag = 2'b00;
    logic [1:0]        rf_ra, rf_rb, rf_wa;
    logic              rf_we, rf_wsel, mem_we;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        flags;
    logic              halted;

    logic [7:0] rom [256];
    int n_checks = 0;
    int n_pass   = 0;

    // Snapshot of DUT outputs taken by cyc().
    logic [9:0] o_ctl;
    logic [7:0] o_pc;
    logic [5:0] o_regs;
    logic [1:0] o_flags;

    control_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .alu_sel(alu_sel), .alu_flag(alu_flag),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .mem_we(mem_we), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .flags(flags), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM: data appears one cycle after the address.
    always @(posedge clk) instr <= rom[pc];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected control vector {alu_sel, rf_we, rf_we&rf_wsel, mem_we, in_ready, out_valid, halted}.
    function automatic logic [9:0] ec(input logic [3:0] s, input logic we, input logic ws,
                                      input logic mwe, input logic ir, input logic ov, input logic h);
        return {s, we, ws, mwe, ir, ov, h};
    endfunction

    // One clock: drive inputs at the falling edge, then sample outputs just after.
    task automatic cyc(input logic r, input logic [1:0] af, input logic iv, input logic ordy);
        @(negedge clk);
        rst = r; alu_flag = af; in_valid = iv; out_ready = ordy;
        #1;
        o_ctl   = {alu_sel, rf_we, rf_we & rf_wsel, mem_we, in_ready, out_valid, halted};
        o_pc    = pc;
        o_regs  = {rf_ra, rf_rb, rf_wa};
        o_flags = flags;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        clear_rom();
        do_reset();
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'h00 || o_ctl !== 10'd0 || o_flags !== 2'b00)
            $display("FAIL reset_state: pc=%h ctl=%h flags=%b, want pc=00 ctl=000 flags=00", o_pc, o_ctl, o_flags);
        else n_pass++;
    endtask

    task automatic test_add();
        clear_rom();
        rom[0] = 8'h16;                    // ADD r1,r2
        do_reset();
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_ctl !== 10'd0) $display("FAIL add_c1: ctl=%h want 000", o_ctl); else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_ctl !== 10'd0) $display("FAIL add_c2: ctl=%h want 000", o_ctl); else n_pass++;
        cyc(1'b0, 2'b10, 1'b0, 1'b0);
        n_checks++;
        if (o_ctl !== ec(4'h1, 1, 0, 0, 0, 0, 0) || o_regs !== {2'b01, 2'b10, 2'b01})
            $display("FAIL add_exec: ctl=%h regs=%b want ctl=%h regs=011001", o_ctl, o_regs, ec(4'h1, 1, 0, 0, 0, 0, 0));
        else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'h01 || o_flags !== 2'b10 || o_ctl !== 10'd0)
            $display("FAIL add_after: pc=%h flags=%b ctl=%h want pc=01 flags=10 ctl=000", o_pc, o_flags, o_ctl);
        else n_pass++;
    endtask

    task automatic test_branch();
        // BZ with flags=00 (fresh from reset): not taken, resume after the target byte.
        clear_rom();
        rom[0] = 8'hA0; rom[1] = 8'h40;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 2'($urandom), 1'b0, 1'b0);
            n_checks++;
            if (o_ctl !== 10'd0) $display("FAIL bz_nt_strobe c=%0d: ctl=%h want 000", c, o_ctl); else n_pass++;
        end
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'h02) $display("FAIL bz_not_taken: pc=%h want 02", o_pc); else n_pass++;

        // ADD leaves Z set, then the same BZ is taken.
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'hA0; rom[2] = 8'h40;
        do_reset();
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b10, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) cyc(1'b0, 2'b01, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'h40 || o_flags !== 2'b10)
            $display("FAIL bz_taken: pc=%h flags=%b want pc=40 flags=10", o_pc, o_flags);
        else n_pass++;
    endtask

    task automatic test_in();
        clear_rom();
        rom[0] = 8'h7C;                    // IN r3
        do_reset();
        // in_valid high before WAIT_IN must be ignored.
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        n_checks++;
        if (o_ctl !== 10'd0) $display("FAIL in_early_ignored: ctl=%h want 000", o_ctl); else n_pass++;
        for (int w = 0; w < 5; w++) begin
            cyc(1'b0, 2'b00, 1'b0, 1'b0);
            n_checks++;
            if (o_ctl !== ec(4'h7, 0, 0, 0, 1, 0, 0))
                $display("FAIL in_wait w=%0d: ctl=%h want %h", w, o_ctl, ec(4'h7, 0, 0, 0, 1, 0, 0));
            else n_pass++;
        end
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        n_checks++;
        if (o_ctl !== ec(4'h7, 1, 1, 0, 1, 0, 0) || o_regs[1:0] !== 2'b11)
            $display("FAIL in_transfer: ctl=%h wa=%b want ctl=%h wa=11", o_ctl, o_regs[1:0], ec(4'h7, 1, 1, 0, 1, 0, 0));
        else n_pass++;
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        n_checks++;
        if (o_pc !== 8'h01 || o_ctl !== 10'd0)
            $display("FAIL in_after: pc=%h ctl=%h want pc=01 ctl=000", o_pc, o_ctl);
        else n_pass++;
    endtask

    task automatic test_out_shl();
        clear_rom();
        rom[0] = 8'h60; rom[1] = 8'h40; rom[2] = 8'h10; rom[3] = 8'h50;   // OUT, SHL, ADD, SHR
        do_reset();
        cyc(1'b0, 2'b00, 1'b0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 1'b1);
        n_checks++;
        if (o_ctl !== ec(4'h6, 0, 0, 0, 0, 1, 0))
            $display("FAIL out_xfer: ctl=%h want %h", o_ctl, ec(4'h6, 0, 0, 0, 0, 1, 0));
        else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b1);
        n_checks++;
        if (o_pc !== 8'h01 || o_ctl !== 10'd0)
            $display("FAIL out_one_cycle: pc=%h ctl=%h want pc=01 ctl=000", o_pc, o_ctl);
        else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (o_ctl !== ec(4'h4, 1, 0, 0, 0, 0, 0)) $display("FAIL shl_exec: ctl=%h want %h", o_ctl, ec(4'h4, 1, 0, 0, 0, 0, 0)); else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_flags !== 2'b10) $display("FAIL shl_flags: flags=%b want 10", o_flags); else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b01, 1'b0, 1'b0);      // ADD -> flags 01
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b10, 1'b0, 1'b0);      // SHR: Z from ALU, N kept at 1
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_flags !== 2'b11) $display("FAIL shr_keeps_n: flags=%b want 11", o_flags); else n_pass++;
    endtask

    task automatic test_jmp_wrap_halt();
        clear_rom();
        rom[8'h00] = 8'h10;                // ADD, also JMP target for the 0xFF jump
        rom[8'h01] = 8'hC0; rom[8'h02] = 8'hFF;
        rom[8'hFF] = 8'hC0;
        rom[8'h10] = 8'hF0;                // HLT
        do_reset();
        for (int c = 0; c < 3; c++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'hFF) $display("FAIL jmp_to_ff: pc=%h want ff", o_pc); else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'h00) $display("FAIL jmp_wrap_imm: pc=%h want 00", o_pc); else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'h10) $display("FAIL jmp_wrap_target: pc=%h want 10", o_pc); else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 2'($urandom), 1'b1, 1'b1);
            n_checks++;
            if (o_ctl !== ec(4'h0, 0, 0, 0, 0, 0, 1) || o_pc !== 8'h11)
                $display("FAIL halt c=%0d: ctl=%h pc=%h want ctl=%h pc=11", c, o_ctl, o_pc, ec(4'h0, 0, 0, 0, 0, 0, 1));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h60;    // ADD (flags 11), then OUT stalled
        do_reset();
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b11, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_ctl !== ec(4'h6, 0, 0, 0, 0, 1, 0) || o_flags !== 2'b11)
            $display("FAIL out_stall: ctl=%h flags=%b want ctl=%h flags=11", o_ctl, o_flags, ec(4'h6, 0, 0, 0, 0, 1, 0));
        else n_pass++;
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'h00 || o_ctl !== 10'd0 || o_flags !== 2'b00)
            $display("FAIL rst_mid_out: pc=%h ctl=%h flags=%b want pc=00 ctl=000 flags=00", o_pc, o_ctl, o_flags);
        else n_pass++;

        // Reset coinciding with in_valid in WAIT_IN must not write.
        clear_rom();
        rom[0] = 8'h7C;
        do_reset();
        for (int c = 0; c < 3; c++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 1'b1, 1'b0);
        n_checks++;
        if (o_ctl !== 10'd0) $display("FAIL rst_mid_in_no_write: ctl=%h want 000", o_ctl); else n_pass++;
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (o_pc !== 8'h00 || o_ctl !== 10'd0) $display("FAIL rst_mid_in: pc=%h ctl=%h want pc=00 ctl=000", o_pc, o_ctl); else n_pass++;
    endtask

    // Random programs checked against an instruction-level model.
    task automatic test_random(input int n_instr);
        logic [7:0] mpc, inst;
        logic [3:0] op;
        logic [1:0] rd, rs, mf, af;
        logic       hs, tk;
        logic [9:0] exp;
        for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
        do_reset();
        mpc = 8'h00; mf = 2'b00;
        for (int k = 0; k < n_instr; k++) begin
            inst = rom[mpc]; op = inst[7:4]; rd = inst[3:2]; rs = inst[1:0];
            cyc(1'b0, 2'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if (o_pc !== mpc || o_ctl !== 10'd0 || o_flags !== mf)
                $display("FAIL rnd_fetch k=%0d: pc=%h ctl=%h flags=%b want pc=%h ctl=000 flags=%b", k, o_pc, o_ctl, o_flags, mpc, mf);
            else n_pass++;
            cyc(1'b0, 2'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if (o_ctl !== 10'd0) $display("FAIL rnd_decode k=%0d: ctl=%h want 000", k, o_ctl); else n_pass++;
            if (op == 4'h7 || op == 4'h6) begin
                for (int w = 0; w < 20; w++) begin
                    hs = (w == 19) || ($urandom_range(0, 2) == 0);
                    if (op == 4'h7) begin
                        cyc(1'b0, 2'($urandom), hs, 1'($urandom));
                        exp = ec(4'h7, hs, hs, 0, 1, 0, 0);
                    end else begin
                        cyc(1'b0, 2'($urandom), 1'($urandom), hs);
                        exp = ec(4'h6, 0, 0, 0, 0, 1, 0);
                    end
                    n_checks++;
                    if (o_ctl !== exp || o_regs !== {rd, rs, rd})
                        $display("FAIL rnd_wait k=%0d w=%0d: ctl=%h regs=%b want ctl=%h regs=%b", k, w, o_ctl, o_regs, exp, {rd, rs, rd});
                    else n_pass++;
                    if (hs) break;
                end
                mpc = mpc + 8'd1;
            end else if (op >= 4'hA && op <= 4'hC) begin
                cyc(1'b0, 2'($urandom), 1'($urandom), 1'($urandom));
                n_checks++;
                if (o_pc !== 8'(mpc + 8'd1) || o_ctl !== 10'd0)
                    $display("FAIL rnd_imm k=%0d: pc=%h ctl=%h want pc=%h ctl=000", k, o_pc, o_ctl, 8'(mpc + 8'd1));
                else n_pass++;
                cyc(1'b0, 2'($urandom), 1'($urandom), 1'($urandom));
                n_checks++;
                if (o_ctl !== 10'd0) $display("FAIL rnd_branch k=%0d: ctl=%h want 000", k, o_ctl); else n_pass++;
                tk  = (op == 4'hC) || (op == 4'hA && mf[1]) || (op == 4'hB && mf[0]);
                mpc = tk ? rom[8'(mpc + 8'd1)] : 8'(mpc + 8'd2);
            end else begin
                af = 2'($urandom);
                cyc(1'b0, af, 1'($urandom), 1'($urandom));
                if (op == 4'h9)                                 exp = ec(op, 0, 0, 1, 0, 0, 0);
                else if ((op >= 4'h1 && op <= 4'h5) || op == 4'h8) exp = ec(op, 1, 0, 0, 0, 0, 0);
                else                                            exp = 10'd0;
                n_checks++;
                if (o_ctl !== exp || o_regs !== {rd, rs, rd})
                    $display("FAIL rnd_exec k=%0d op=%h: ctl=%h regs=%b want ctl=%h regs=%b", k, op, o_ctl, o_regs, exp, {rd, rs, rd});
                else n_pass++;
                if (op >= 4'h1 && op <= 4'h3) mf = af;
                else if (op == 4'h4 || op == 4'h5) mf[1] = af[1];
                mpc = mpc + 8'd1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_in();
        test_out_shl();
        test_jmp_wrap_halt();
        test_random(300);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
